// File: rtl/plab5_mcore_mem_arbiter_rr_if.sv
// Request/response channels between N cores, the round-robin arbiter and the
// single main-memory port.
interface plab5_mcore_mem_arbiter_rr_if #(
    parameter int p_num_ports    = 4,
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 32
);
    localparam int len_nbits = $clog2(p_data_nbits / 8);
    localparam int rqc = 3 + p_opaque_nbits + p_addr_nbits + len_nbits;
    localparam int rqd = p_data_nbits;
    localparam int rsc = 3 + p_opaque_nbits + len_nbits;
    localparam int rsd = p_data_nbits;

    // Every channel is val/rdy: a transfer happens on a cycle where both are
    // high, and the sender holds val and payload steady until that cycle.
    logic [p_num_ports-1:0]     in_req_val;
    logic [p_num_ports-1:0]     in_req_rdy;
    logic [p_num_ports*rqc-1:0] in_req_control;
    logic [p_num_ports*rqd-1:0] in_req_data;
    logic [p_num_ports-1:0]     in_req_domain;

    logic                       req_val;
    logic                       req_rdy;
    logic [rqc-1:0]             req_control;
    logic [rqd-1:0]             req_data;
    logic                       req_domain;

    logic                       resp_val;
    logic                       resp_rdy;
    logic [rsc-1:0]             resp_control;
    logic [rsd-1:0]             resp_data;
    logic                       resp_insecure;
    logic                       resp_domain;

    logic [p_num_ports-1:0]     out_resp_val;
    logic [p_num_ports-1:0]     out_resp_rdy;
    logic [p_num_ports*rsc-1:0] out_resp_control;
    logic [p_num_ports*rsd-1:0] out_resp_data;
    logic [p_num_ports-1:0]     out_resp_insecure;
    logic [p_num_ports-1:0]     out_resp_domain;

    modport slave (
        input  in_req_val, in_req_control, in_req_data, in_req_domain,
        output in_req_rdy,
        output req_val, req_control, req_data, req_domain,
        input  req_rdy,
        input  resp_val, resp_control, resp_data, resp_insecure, resp_domain,
        output resp_rdy,
        output out_resp_val, out_resp_control, out_resp_data, out_resp_insecure, out_resp_domain,
        input  out_resp_rdy
    );

    modport master (
        output in_req_val, in_req_control, in_req_data, in_req_domain,
        input  in_req_rdy,
        input  req_val, req_control, req_data, req_domain,
        output req_rdy,
        output resp_val, resp_control, resp_data, resp_insecure, resp_domain,
        input  resp_rdy,
        input  out_resp_val, out_resp_control, out_resp_data, out_resp_insecure, out_resp_domain,
        output out_resp_rdy
    );
endinterface

// File: rtl/plab5_mcore_mem_arbiter_rr.sv
// Round-robin arbiter for N cores sharing one memory port; an in-order tag FIFO
// of {port, domain} steers each response back to its issuer.
module plab5_mcore_mem_arbiter_rr #(
    parameter int p_num_ports       = 4,
    parameter int p_max_outstanding = 4,
    parameter int p_opaque_nbits    = 8,
    parameter int p_addr_nbits      = 32,
    parameter int p_data_nbits      = 32,
    parameter bit p_lock_domain     = 1'b1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    plab5_mcore_mem_arbiter_rr_if.slave            bus,
    output logic [$clog2(p_max_outstanding+1)-1:0] outstanding,
    output logic                                   domain_err
);
    localparam int len_nbits = $clog2(p_data_nbits / 8);
    localparam int rqc = 3 + p_opaque_nbits + p_addr_nbits + len_nbits;
    localparam int rqd = p_data_nbits;
    localparam int rsc = 3 + p_opaque_nbits + len_nbits;
    localparam int rsd = p_data_nbits;
    localparam int iw  = $clog2(p_num_ports);
    localparam int pw  = (p_max_outstanding > 1) ? $clog2(p_max_outstanding) : 1;
    localparam int ow  = $clog2(p_max_outstanding + 1);

    localparam logic [0:0] st_arb  = 1'b0;
    localparam logic [0:0] st_hold = 1'b1;

    logic [0:0]             state;
    logic [iw-1:0]          rr_ptr;
    logic [iw-1:0]          hold_port;
    logic                   lock_dom;
    logic [iw-1:0]          tag_port [p_max_outstanding];
    logic                   tag_dom  [p_max_outstanding];
    logic [pw-1:0]          wr_ptr;
    logic [pw-1:0]          rd_ptr;

    logic [p_num_ports-1:0] eligible;
    logic [iw-1:0]          grant;
    logic [iw-1:0]          rr_next;
    logic                   grant_val;
    logic                   full;
    logic                   empty;
    logic                   fire;
    logic                   pop;
    logic                   match;
    logic                   drop;
    logic [iw-1:0]          head_port;
    logic                   head_dom;
    int                     idx;

    function automatic logic [pw-1:0] ptr_inc(input logic [pw-1:0] p);
        return (p == pw'(p_max_outstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (outstanding == ow'(p_max_outstanding));
    assign empty     = (outstanding == '0);
    assign head_port = tag_port[rd_ptr];
    assign head_dom  = tag_dom[rd_ptr];
    assign rr_next   = (grant == iw'(p_num_ports - 1)) ? '0 : grant + 1'b1;

    // A stalled grant is pinned so the payload on the memory port never changes
    // underneath a waiting request.
    always_comb begin : arbitrate
        eligible  = '0;
        grant     = rr_ptr;
        grant_val = 1'b0;
        idx       = 0;
        for (int i = 0; i < p_num_ports; i++)
            eligible[i] = bus.in_req_val[i] && !full &&
                          (!p_lock_domain || empty || (bus.in_req_domain[i] == lock_dom));
        if (state == st_hold) begin
            grant     = hold_port;
            grant_val = bus.in_req_val[hold_port] && !full;
        end else begin
            for (int k = 0; k < p_num_ports; k++) begin
                idx = (int'(rr_ptr) + k) % p_num_ports;
                if (!grant_val && eligible[iw'(idx)]) begin
                    grant_val = 1'b1;
                    grant     = iw'(idx);
                end
            end
        end
        grant_val = grant_val && reset;
    end

    always_comb begin : req_mux
        bus.req_val     = grant_val;
        bus.req_control = '0;
        bus.req_data    = '0;
        bus.req_domain  = 1'b0;
        bus.in_req_rdy  = '0;
        if (grant_val) begin
            bus.req_control       = bus.in_req_control[grant*rqc +: rqc];
            bus.req_data          = bus.in_req_data[grant*rqd +: rqd];
            bus.req_domain        = bus.in_req_domain[grant];
            bus.in_req_rdy[grant] = bus.req_rdy;
        end
    end

    assign fire  = grant_val && bus.req_rdy;
    assign match = reset && !empty && (bus.resp_domain == head_dom);
    assign pop   = match && bus.resp_val && bus.out_resp_rdy[head_port];
    assign drop  = reset && bus.resp_val && !match;

    // Only the head's port sees response fields; everyone else reads zeros.
    always_comb begin : resp_route
        bus.resp_rdy          = 1'b1;
        bus.out_resp_val      = '0;
        bus.out_resp_control  = '0;
        bus.out_resp_data     = '0;
        bus.out_resp_insecure = '0;
        bus.out_resp_domain   = '0;
        if (match) begin
            bus.resp_rdy                                 = bus.out_resp_rdy[head_port];
            bus.out_resp_val[head_port]                  = bus.resp_val;
            bus.out_resp_control[head_port*rsc +: rsc]   = bus.resp_control;
            bus.out_resp_data[head_port*rsd +: rsd]      = bus.resp_data;
            bus.out_resp_insecure[head_port]             = bus.resp_insecure;
            bus.out_resp_domain[head_port]               = bus.resp_domain;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= st_arb;
            hold_port   <= '0;
            rr_ptr      <= '0;
            lock_dom    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            domain_err  <= 1'b0;
        end else begin
            domain_err <= drop;
            state      <= (grant_val && !bus.req_rdy) ? st_hold : st_arb;
            hold_port  <= grant;
            if (fire) begin
                rr_ptr   <= rr_next;
                lock_dom <= bus.in_req_domain[grant];
                wr_ptr   <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({fire, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Tag storage needs no reset: the pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (fire) begin
            tag_port[wr_ptr] <= grant;
            tag_dom[wr_ptr]  <= bus.in_req_domain[grant];
        end
    end
endmodule
